inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter B, default 32, instruction word width in bits.
REQ-002 Parameter W, default 5, word-address bits; memory depth is 2**W words.
REQ-003 Parameter PC, default 32, byte-address width.
REQ-004 Parameter HALT_INST, default 32'hFFFF_FFFF, end-of-program word.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 i_clk  in  1  clock; all state updates on the rising edge.
REQ-007 i_reset  in  1  asynchronous, active-high reset.
REQ-008 i_start  in  1  one-cycle pulse that starts a load at word 0.
REQ-009 i_rx_valid  in  1  one-cycle pulse marking a valid received byte.
REQ-010 i_rx_data  in  8  received byte, sampled when i_rx_valid=1.
REQ-011 o_write  out  1  memory write strobe, one cycle per word.
REQ-012 o_addr  out  PC  byte address of the word being written (word index << 2).
REQ-013 o_data  out  B  assembled instruction word.
REQ-014 o_busy  out  1  high in RECV and WRITE.
REQ-015 o_done  out  1  high in DONE.
REQ-016 o_full  out  1  high in DONE when the load ended on capacity without HALT_INST.
REQ-017 o_word_count  out  W+1  number of words written in the current or last load.

Function
REQ-018 The FSM SHALL have four states: IDLE, RECV, WRITE, DONE.
REQ-019 IDLE: i_rx_valid is ignored; on i_start the FSM SHALL clear the byte count, word index and o_word_count, then go to RECV.
REQ-020 RECV: each i_rx_valid byte SHALL be placed little-endian (byte k -> bits [8k+7:8k]); on the 4th byte the FSM SHALL go to WRITE in the next cycle.
REQ-021 WRITE lasts exactly one cycle with o_write=1, o_addr={index,2'b00} zero-extended to PC, and o_data=the assembled word; o_word_count SHALL increment in the same cycle.
REQ-022 Latency: the 4th-byte edge to o_write=1 SHALL be one cycle.
REQ-023 After WRITE, if o_data==HALT_INST the FSM SHALL go to DONE with o_full=0.
REQ-024 Otherwise, if the index equals 2**W-1, the FSM SHALL go to DONE with o_full=1.
REQ-025 Otherwise the index SHALL increment and the FSM SHALL return to RECV.
REQ-026 An i_rx_valid in WRITE SHALL be captured as byte 0 of the next word when the load continues, and discarded when the load terminates.
REQ-027 i_start in RECV or WRITE SHALL be ignored.
REQ-028 DONE: i_rx_valid is ignored, and o_word_count and o_full hold; on i_start the FSM SHALL behave as in IDLE (restart at word 0, clear o_full).
REQ-029 o_write SHALL be 0 in every state except WRITE; o_addr/o_data SHALL hold the last written values outside WRITE.
REQ-030 The HALT_INST word itself SHALL be written to memory.

Reset
REQ-031 Asserting i_reset at any time, including mid-word or during WRITE, SHALL force IDLE, zero the byte count, index, and assembly register, and set every output to 0.
REQ-032 A partially received word at reset SHALL be discarded, and no o_write SHALL be generated during or after reset.

Structure
REQ-033 FSM state encodings and the default HALT_INST SHALL live in a shared defines/package file used by the pipeline debug unit.
REQ-034 Byte shifting and the 2-bit byte counter SHALL be a sub-module, word_assembler (inputs valid/byte/clear; outputs word and word_ready).
REQ-035 o_write/o_addr/o_data SHALL connect directly to the instruction memory write port with no glue logic.

Verification
REQ-036 Reset, i_start, bytes 13,00,A0,E3 then FF,FF,FF,FF -> two writes: addr 0 data 32'hE3A00013, addr 4 data 32'hFFFFFFFF; then o_done=1, o_full=0, o_word_count=2.
REQ-037 W=2: 16 bytes of 32'h00000001 -> writes to addr 0,4,8,12; then o_done=1, o_full=1, o_word_count=4; a 17th byte produces no write.
REQ-038 A byte pulse arriving in the WRITE cycle of word 0 -> it becomes byte 0 of word 1; after 3 more bytes the second write is at addr 4 with the expected value.
REQ-039 i_reset after 2 bytes, then i_start and 4 bytes 11,22,33,44 -> a single write at addr 0 with data 32'h44332211; no stale bytes.
REQ-040 i_start pulsed in RECV -> ignored, index unchanged; i_start in DONE -> o_done=0, o_word_count=0, and the next word writes to addr 0.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_loader_pkg
// Shared definitions for the instruction loader and the pipeline debug unit:
// loader FSM state encodings, the default end-of-program word and byte-lane
// geometry used by the word assembler.
// -----------------------------------------------------------------------------
package inst_loader_pkg;

    // Loader FSM states (encodings are visible to the debug unit)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    // Default end-of-program marker
    localparam logic [31:0] DEFAULT_HALT_INST = 32'hFFFF_FFFF;

    // Byte-lane geometry
    localparam int          BYTE_W         = 8;
    localparam logic [1:0]  LAST_BYTE_IDX  = 2'd3;

    // True when the byte counter points at the final lane of a word
    function automatic logic is_last_byte(input logic [1:0] cnt);
        return (cnt == LAST_BYTE_IDX);
    endfunction

endpackage : inst_loader_pkg

// File: rtl/inst_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Collects received bytes little-endian into a B-bit word (byte k lands in
// bits [8k+7:8k]) using a 2-bit byte counter.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-high reset, clears word and counter
//   i_clear      synchronous clear of word and counter
//   i_valid      accept i_byte this cycle
//   i_byte       received byte
//   o_word       assembled word, already including i_byte when i_valid=1
//   o_word_ready high while the byte being accepted completes the word
// -----------------------------------------------------------------------------
module word_assembler
    import inst_loader_pkg::*;
#(
    parameter int B = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [B-1:0]      o_word,
    output logic              o_word_ready
);

    logic [B-1:0] word_q;
    logic [B-1:0] word_d;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic [B-1:0] merged_s;

    // Merge the incoming byte into its lane and compute the next register state
    always_comb begin
        merged_s = word_q;
        merged_s[{cnt_q, 3'b000} +: BYTE_W] = i_byte;
        word_d   = word_q;
        cnt_d    = cnt_q;
        if (i_clear) begin
            word_d = '0;
            cnt_d  = 2'd0;
        end else if (i_valid) begin
            word_d = merged_s;
            cnt_d  = cnt_q + 2'd1;   // wraps to 0 after the last lane
        end else begin
            word_d = word_q;
            cnt_d  = cnt_q;
        end
    end

    // The completed word is presented in the same cycle its last byte arrives
    always_comb begin
        o_word       = i_valid ? merged_s : word_q;
        o_word_ready = i_valid & is_last_byte(cnt_q);
    end

    // Assembly register and byte counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule : word_assembler

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Loads a program received as a byte stream into instruction memory. Bytes are
// assembled little-endian into words; each complete word is written at
// consecutive word addresses starting at 0. Loading ends after the HALT_INST
// word has been written or when the memory is full.
//
// Ports
//   i_clk         clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_start       pulse: begin a load at word 0 (honoured in IDLE and DONE)
//   i_rx_valid    pulse: i_rx_data holds a received byte
//   i_rx_data     received byte
//   o_write       memory write strobe, one cycle per word
//   o_addr        byte address of the written word ({index,2'b00})
//   o_data        written instruction word
//   o_busy        loading (RECV or WRITE)
//   o_done        load finished (DONE)
//   o_full        load ended on capacity without seeing HALT_INST
//   o_word_count  words written in the current or last load
// -----------------------------------------------------------------------------
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int           B         = 32,
    parameter int           W         = 5,
    parameter int           PC        = 32,
    parameter logic [B-1:0] HALT_INST = DEFAULT_HALT_INST
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [BYTE_W-1:0] i_rx_data,
    output logic              o_write,
    output logic [PC-1:0]     o_addr,
    output logic [B-1:0]      o_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_full,
    output logic [W:0]        o_word_count
);

    localparam logic [W-1:0] IDX_MAX = '1;

    loader_state_e state_q;
    loader_state_e state_d;
    logic [W-1:0]  index_q;
    logic [W-1:0]  index_d;
    logic [W:0]    word_count_q;
    logic [W:0]    word_count_d;
    logic          full_q;
    logic          full_d;
    logic          write_q;
    logic          write_d;
    logic [PC-1:0] addr_q;
    logic [PC-1:0] addr_d;
    logic [B-1:0]  data_q;
    logic [B-1:0]  data_d;
    logic          busy_q;
    logic          busy_d;
    logic          done_q;
    logic          done_d;

    logic          asm_valid_s;
    logic          asm_clear_s;
    logic [B-1:0]  asm_word_s;
    logic          asm_ready_s;

    word_assembler #(
        .B (B)
    ) u_word_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (asm_clear_s),
        .i_valid      (asm_valid_s),
        .i_byte       (i_rx_data),
        .o_word       (asm_word_s),
        .o_word_ready (asm_ready_s)
    );

    // Next-state, byte gating and output register inputs
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        word_count_d = word_count_q;
        full_d       = full_q;
        addr_d       = addr_q;
        data_d       = data_q;
        write_d      = 1'b0;
        asm_valid_s  = 1'b0;
        asm_clear_s  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Received bytes are ignored here; counts and o_full hold
                if (i_start) begin
                    asm_clear_s  = 1'b1;
                    index_d      = '0;
                    word_count_d = '0;
                    full_d       = 1'b0;
                    state_d      = ST_RECV;
                end else begin
                    state_d = state_q;
                end
            end

            ST_RECV: begin
                asm_valid_s = i_rx_valid;
                // The word is registered on its last byte so WRITE presents it
                if (asm_ready_s) begin
                    write_d      = 1'b1;
                    addr_d       = PC'({index_q, 2'b00});
                    data_d       = asm_word_s;
                    word_count_d = word_count_q + (W+1)'(1);
                    state_d      = ST_WRITE;
                end else begin
                    state_d = ST_RECV;
                end
            end

            ST_WRITE: begin
                // data_q is the word being written this cycle
                if (data_q == HALT_INST) begin
                    full_d      = 1'b0;
                    asm_clear_s = 1'b1;
                    state_d     = ST_DONE;
                end else if (index_q == IDX_MAX) begin
                    full_d      = 1'b1;
                    asm_clear_s = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    // A byte arriving now is the first byte of the next word
                    asm_valid_s = i_rx_valid;
                    index_d     = index_q + W'(1);
                    state_d     = ST_RECV;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            word_count_q <= '0;
            full_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            word_count_q <= word_count_d;
            full_q       <= full_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_write      = write_q;
    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_full       = full_q;
    assign o_word_count = word_count_q;

endmodule : inst_loader

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
// Directed bench for inst_loader. A default-size loader (W=5) and a small one
// (W=2) share clock, reset and the byte stream; each has its own start pulse.
// Expected memory writes are queued as stimulus is driven and compared by a
// per-instance monitor whenever that instance strobes o_write.
// -----------------------------------------------------------------------------
module tb_inst_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        s_start;
    logic        rx_valid;
    logic [7:0]  rx_data;

    logic        o_write,  s_write;
    logic [31:0] o_addr,   s_addr;
    logic [31:0] o_data,   s_data;
    logic        o_busy,   s_busy;
    logic        o_done,   s_done;
    logic        o_full,   s_full;
    logic [5:0]  o_count;
    logic [2:0]  s_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];     // {addr, data} for the W=5 instance
    logic [63:0] exp_s_q[$];   // {addr, data} for the W=2 instance

    inst_loader #(.B(32), .W(5), .PC(32), .HALT_INST(32'hFFFF_FFFF)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_write(o_write), .o_addr(o_addr), .o_data(o_data),
        .o_busy(o_busy), .o_done(o_done), .o_full(o_full),
        .o_word_count(o_count)
    );

    inst_loader #(.B(32), .W(2), .PC(32), .HALT_INST(32'hFFFF_FFFF)) dut_s (
        .i_clk(clk), .i_reset(rst), .i_start(s_start),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_write(s_write), .o_addr(s_addr), .o_data(s_data),
        .o_busy(s_busy), .o_done(s_done), .o_full(s_full),
        .o_word_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitors: every write strobe must match the head of its queue
    always @(negedge clk) begin
        if (o_write === 1'b1) begin
            if (exp_q.size() == 0) check("big_extra_write", 64'(o_write), 64'd0);
            else check("big_write", {o_addr, o_data}, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (s_write === 1'b1) begin
            if (exp_s_q.size() == 0) check("small_extra_write", 64'(s_write), 64'd0);
            else check("small_write", {s_addr, s_data}, exp_s_q.pop_front());
        end
    end

    // All tasks start and end one time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 64'({o_write, o_busy, o_done, o_full}), 64'd0);
        check({tag, "_addr"},  64'(o_addr),  64'd0);
        check({tag, "_data"},  64'(o_data),  64'd0);
        check({tag, "_count"}, 64'(o_count), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // Basic program: one instruction then HALT
        pulse_start();
        check("busy_after_start", 64'(o_busy), 64'd1);
        exp_q.push_back({32'd0, 32'hE3A0_0013});
        send_byte(8'h13); send_byte(8'h00); send_byte(8'hA0); send_byte(8'hE3);
        check("write_latency", 64'(o_write), 64'd1);
        check("count_in_write", 64'(o_count), 64'd1);
        tick(1);
        exp_q.push_back({32'd4, 32'hFFFF_FFFF});
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        tick(2);
        check("halt_done", 64'(o_done), 64'd1);
        check("halt_full", 64'(o_full), 64'd0);
        check("halt_count", 64'(o_count), 64'd2);
        check("halt_busy", 64'(o_busy), 64'd0);
        check("hold_addr_data", {o_addr, o_data}, {32'd4, 32'hFFFF_FFFF});

        // Bytes in DONE are ignored
        send_byte(8'h55);
        tick(2);
        check("done_ignores_rx", 64'(o_count), 64'd2);

        // Restart from DONE
        pulse_start();
        check("restart_done", 64'(o_done), 64'd0);
        check("restart_count", 64'(o_count), 64'd0);

        // i_start in RECV and WRITE is ignored
        exp_q.push_back({32'd0, 32'hDDCC_BBAA});
        send_byte(8'hAA); send_byte(8'hBB);
        pulse_start();
        send_byte(8'hCC); send_byte(8'hDD);
        pulse_start();                         // lands in the WRITE cycle
        exp_q.push_back({32'd4, 32'h1234_5678});
        send_byte(8'h78);
        pulse_start();
        send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        tick(1);
        check("start_ignored_count", 64'(o_count), 64'd2);

        // Reset mid-word discards the partial word
        send_byte(8'h99); send_byte(8'h88);
        rst = 1'b1;
        #1;
        check_all_zero("reset_midword");
        tick(2);
        rst = 1'b0;
        tick(1);
        pulse_start();
        exp_q.push_back({32'd0, 32'h4433_2211});
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        // Byte in the WRITE cycle of word 0 becomes byte 0 of word 1
        exp_q.push_back({32'd4, 32'hFFFF_FF00});
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        tick(1);
        check("rx_in_write_count", 64'(o_count), 64'd2);
        exp_q.push_back({32'd8, 32'hFFFF_FFFF});
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h77);                      // WRITE cycle of HALT: discarded
        tick(2);
        check("terminal_rx_done", 64'(o_done), 64'd1);
        check("terminal_rx_count", 64'(o_count), 64'd3);

        // Reset during WRITE suppresses the strobe
        pulse_start();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        rst = 1'b1;
        #1;
        check_all_zero("reset_in_write");
        tick(2);
        rst = 1'b0;
        tick(3);
        check("idle_after_reset", 64'({o_busy, o_done}), 64'd0);

        // Capacity end on the W=2 instance
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            exp_s_q.push_back({32'(w * 4), 32'h0000_0001});
        end
        for (int w = 0; w < 4; w++) begin
            send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        end
        send_byte(8'h5A);                      // 17th byte, no write
        send_byte(8'h5B);
        tick(2);
        check("full_done", 64'(s_done), 64'd1);
        check("full_flag", 64'(s_full), 64'd1);
        check("full_count", 64'(s_count), 64'd4);
        check("full_busy", 64'(s_busy), 64'd0);

        tick(2);
        check("big_queue_drained", 64'(exp_q.size()), 64'd0);
        check("small_queue_drained", 64'(exp_s_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_inst_loader
